// File: rtl/core_mem.sv
// core_mem: memory-access pipeline stage between EX and WB.
// Ports: EX handshake and operands in, data-bus req/gnt/rvalid, WB bundle out.
module core_mem #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid_i,
    output logic               ex_ready_o,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [XLEN-1:0]    instr_i,
    input  logic [RFIDX_W-1:0] rsd_idx_i,
    input  logic               rf_wen_i,
    input  logic [XLEN-1:0]    alu_res_i,
    input  logic [XLEN-1:0]    store_data_i,
    input  logic               ld_i,
    input  logic               st_i,
    input  logic [1:0]         size_i,
    input  logic               unsigned_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [XLEN-1:0]    dmem_addr_o,
    output logic [3:0]         dmem_be_o,
    output logic [XLEN-1:0]    dmem_wdata_o,
    input  logic               dmem_gnt_i,
    input  logic               dmem_rvalid_i,
    input  logic [XLEN-1:0]    dmem_rdata_i,
    output logic               wb_valid_o,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    instr_o,
    output logic [RFIDX_W-1:0] rsd_idx_o,
    output logic [XLEN-1:0]    rsd_data_o,
    output logic               rf_wen_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               accept;
    logic               is_mem;
    logic               mis_in;
    logic               fast_done;

    logic [XLEN-1:0]    pc_q;
    logic [XLEN-1:0]    instr_q;
    logic [RFIDX_W-1:0] idx_q;
    logic               wen_q;
    logic [XLEN-1:0]    addr_q;
    logic [XLEN-1:0]    sdata_q;
    logic               st_q;
    logic [1:0]         size_q;
    logic               uns_q;

    logic [XLEN-1:0]    ld_shift;
    logic [XLEN-1:0]    ld_data;
    logic               store_done;
    logic               load_done;

    assign ex_ready_o = (state == IDLE);
    assign accept     = ex_valid_i && ex_ready_o;
    assign is_mem     = ld_i || st_i;

    // size_i[1] covers word (and the unused 2'b11 code, treated as word)
    assign mis_in = is_mem &&
                    (((size_i == 2'b01) && alu_res_i[0]) ||
                     (size_i[1] && (alu_res_i[1:0] != 2'b00)));

    // Instructions that complete straight out of IDLE without the bus
    assign fast_done  = accept && (!is_mem || mis_in);
    assign store_done = (state == REQ) && dmem_gnt_i && st_q;
    assign load_done  = (state == WAIT) && dmem_rvalid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && is_mem && !mis_in) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_nxt = st_q ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dmem_rvalid_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            instr_q <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
            st_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else if (accept) begin
            pc_q    <= pc_i;
            instr_q <= instr_i;
            idx_q   <= rsd_idx_i;
            wen_q   <= rf_wen_i;
            addr_q  <= alu_res_i;
            sdata_q <= store_data_i;
            st_q    <= st_i;
            size_q  <= size_i;
            uns_q   <= unsigned_i;
        end
    end

    assign dmem_req_o  = (state == REQ);
    assign dmem_we_o   = st_q;
    assign dmem_addr_o = {addr_q[XLEN-1:2], 2'b00};

    always_comb begin
        dmem_be_o    = 4'b1111;
        dmem_wdata_o = sdata_q;
        unique case (size_q)
            2'b00: begin
                dmem_be_o    = 4'b0001 << addr_q[1:0];
                dmem_wdata_o = {4{sdata_q[7:0]}};
            end
            2'b01: begin
                dmem_be_o    = 4'b0011 << addr_q[1:0];
                dmem_wdata_o = {2{sdata_q[15:0]}};
            end
            default: begin
                dmem_be_o    = 4'b1111;
                dmem_wdata_o = sdata_q;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend
    assign ld_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = dmem_rdata_i;
        unique case (size_q)
            2'b00: ld_data = {{(XLEN-8){~uns_q & ld_shift[7]}},
                              ld_shift[7:0]};
            2'b01: ld_data = {{(XLEN-16){~uns_q & ld_shift[15]}},
                              ld_shift[15:0]};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_o <= 1'b0;
            pc_o       <= '0;
            instr_o    <= '0;
            rsd_idx_o  <= '0;
            rsd_data_o <= '0;
            rf_wen_o   <= 1'b0;
            misalign_o <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            if (fast_done) begin
                wb_valid_o <= 1'b1;
                pc_o       <= pc_i;
                instr_o    <= instr_i;
                rsd_idx_o  <= rsd_idx_i;
                rsd_data_o <= alu_res_i;
                rf_wen_o   <= rf_wen_i && !mis_in;
                misalign_o <= mis_in;
            end else if (store_done) begin
                wb_valid_o <= 1'b1;
                pc_o       <= pc_q;
                instr_o    <= instr_q;
                rsd_idx_o  <= idx_q;
                rf_wen_o   <= 1'b0;
                misalign_o <= 1'b0;
            end else if (load_done) begin
                wb_valid_o <= 1'b1;
                pc_o       <= pc_q;
                instr_o    <= instr_q;
                rsd_idx_o  <= idx_q;
                rsd_data_o <= ld_data;
                rf_wen_o   <= wen_q;
                misalign_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: randomized + directed bench for core_mem against a
// behavioural model; one compare process checks outputs every cycle.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic [4:0]  rsd_idx_i;
    logic        rf_wen_i;
    logic [31:0] alu_res_i;
    logic [31:0] store_data_i;
    logic        ld_i;
    logic        st_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [4:0]  rsd_idx_o;
    logic [31:0] rsd_data_o;
    logic        rf_wen_o;
    logic        misalign_o;

    core_mem #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .pc_i(pc_i), .instr_i(instr_i), .rsd_idx_i(rsd_idx_i),
        .rf_wen_i(rf_wen_i), .alu_res_i(alu_res_i),
        .store_data_i(store_data_i), .ld_i(ld_i), .st_i(st_i),
        .size_i(size_i), .unsigned_i(unsigned_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .wb_valid_o(wb_valid_o), .pc_o(pc_o), .instr_o(instr_o),
        .rsd_idx_o(rsd_idx_o), .rsd_data_o(rsd_data_o),
        .rf_wen_o(rf_wen_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Expected DUT state after the coming rising edge
    logic        cmp_en = 1'b0;
    logic        exp_wb, exp_ready, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_pc, exp_instr, exp_data;
    logic [4:0]  exp_idx;
    logic        exp_wen, exp_mis, chk_data;
    logic        pin_en = 1'b0;
    logic [31:0] pin_addr, pin_wdata;
    logic [3:0]  pin_be;
    int          req_cycles = 0;

    function automatic logic model_mis(input logic mem, input logic [1:0] sz,
                                       input logic [31:0] a);
        return mem && ((sz == 1 && (a % 2) != 0) || (sz == 2 && (a % 4) != 0));
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz,
                                            input logic [31:0] a);
        int lane = int'(a % 4);
        if (sz == 0) return 4'(1 << lane);
        if (sz == 1) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz,
                                                input logic [31:0] d);
        if (sz == 0) return (d % 256) * 32'h01010101;
        if (sz == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_ld(input logic [31:0] rd,
                                             input logic [31:0] a,
                                             input logic [1:0] sz,
                                             input logic uns);
        logic [31:0] v;
        if (sz == 2) return rd;
        v = rd >> (8 * (a % 4));
        if (sz == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        #1;
        if (dmem_req_o) req_cycles++;
        if (cmp_en) begin
            chk("wb_valid", 32'(wb_valid_o), 32'(exp_wb));
            chk("ex_ready", 32'(ex_ready_o), 32'(exp_ready));
            chk("dmem_req", 32'(dmem_req_o), 32'(exp_req));
            if (exp_req) begin
                chk("dmem_we", 32'(dmem_we_o), 32'(exp_we));
                chk("dmem_addr", dmem_addr_o, exp_addr);
                chk("dmem_be", 32'(dmem_be_o), 32'(exp_be));
                chk("dmem_wdata", dmem_wdata_o, exp_wdata);
                if (pin_en) begin
                    chk("pin_addr", dmem_addr_o, pin_addr);
                    chk("pin_be", 32'(dmem_be_o), 32'(pin_be));
                    chk("pin_wdata", dmem_wdata_o, pin_wdata);
                end
            end
            chk("pc_o", pc_o, exp_pc);
            chk("instr_o", instr_o, exp_instr);
            chk("rsd_idx", 32'(rsd_idx_o), 32'(exp_idx));
            chk("rf_wen", 32'(rf_wen_o), 32'(exp_wen));
            chk("misalign", 32'(misalign_o), 32'(exp_mis));
            if (chk_data) chk("rsd_data", rsd_data_o, exp_data);
        end
    end

    // Random operands while the stage is busy; they must be ignored
    task automatic junk();
        int k;
        ex_valid_i   = 1'($urandom % 2);
        pc_i         = $urandom;
        instr_i      = $urandom;
        rsd_idx_i    = 5'($urandom);
        rf_wen_i     = 1'($urandom % 2);
        alu_res_i    = $urandom;
        store_data_i = $urandom;
        k            = int'($urandom % 3);
        ld_i         = (k == 1);
        st_i         = (k == 2);
        size_i       = 2'($urandom % 3);
        unsigned_i   = 1'($urandom % 2);
    endtask

    task automatic set_wb(input logic [31:0] pc, input logic [31:0] ins,
                          input logic [4:0] idx, input logic wen,
                          input logic mis, input logic dchk,
                          input logic [31:0] data);
        exp_wb    = 1'b1;
        exp_ready = 1'b1;
        exp_pc    = pc;
        exp_instr = ins;
        exp_idx   = idx;
        exp_wen   = wen;
        exp_mis   = mis;
        chk_data  = dchk;
        exp_data  = data;
    endtask

    // Called at a falling edge with the stage idle
    task automatic do_op(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [4:0] idx, input logic wen,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input logic ld, input logic st,
                         input logic [1:0] sz, input logic uns,
                         input int gd, input int rd, input int spur,
                         input logic [31:0] rdata);
        logic mis;
        mis          = model_mis(ld || st, sz, alu);
        ex_valid_i   = 1'b1;
        pc_i         = pc;
        instr_i      = ins;
        rsd_idx_i    = idx;
        rf_wen_i     = wen;
        alu_res_i    = alu;
        store_data_i = sd;
        ld_i         = ld;
        st_i         = st;
        size_i       = sz;
        unsigned_i   = uns;
        if (!(ld || st) || mis) begin
            exp_req = 1'b0;
            set_wb(pc, ins, idx, wen && !mis, mis, !mis, alu);
            @(negedge clk);
        end else begin
            exp_wb    = 1'b0;
            exp_ready = 1'b0;
            exp_req   = 1'b1;
            exp_we    = st;
            exp_addr  = alu - (alu % 4);
            exp_be    = model_be(sz, alu);
            exp_wdata = model_wdata(sz, sd);
            @(negedge clk);
            for (int k = 0; k < gd; k++) begin
                junk();
                dmem_gnt_i    = 1'b0;
                dmem_rvalid_i = 1'($urandom % 2);
                dmem_rdata_i  = $urandom;
                @(negedge clk);
            end
            junk();
            dmem_gnt_i    = 1'b1;
            dmem_rvalid_i = (spur == 2) ? 1'($urandom % 2) : 1'(spur);
            dmem_rdata_i  = $urandom;
            exp_req       = 1'b0;
            if (st) set_wb(pc, ins, idx, 1'b0, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
            if (ld) begin
                exp_wb = 1'b0;
                for (int k = 0; k < rd; k++) begin
                    junk();
                    dmem_gnt_i    = 1'($urandom % 2);
                    dmem_rvalid_i = 1'b0;
                    @(negedge clk);
                end
                junk();
                dmem_gnt_i    = 1'($urandom % 2);
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = rdata;
                set_wb(pc, ins, idx, wen, 1'b0, 1'b1,
                       model_ld(rdata, alu, sz, uns));
                @(negedge clk);
            end
        end
        ex_valid_i    = 1'b0;
        dmem_gnt_i    = 1'($urandom % 2);
        dmem_rvalid_i = 1'($urandom % 2);
        exp_wb        = 1'b0;
        exp_ready     = 1'b1;
        exp_req       = 1'b0;
    endtask

    task automatic clear_exp();
        exp_wb    = 1'b0;
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_pc    = '0;
        exp_instr = '0;
        exp_idx   = '0;
        exp_wen   = 1'b0;
        exp_mis   = 1'b0;
        exp_data  = '0;
        chk_data  = 1'b1;
    endtask

    initial begin
        int r;
        int req0;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        isld;
        rst_n = 1'b0;
        ex_valid_i = 1'b0;
        junk();
        ex_valid_i    = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        clear_exp();
        repeat (3) @(negedge clk);
        chk("rst_wb", 32'(wb_valid_o), 32'h0);
        chk("rst_ready", 32'(ex_ready_o), 32'h1);
        chk("rst_req", 32'(dmem_req_o), 32'h0);
        chk("rst_data", rsd_data_o, 32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        do_op(32'h100, 32'h13, 5'd5, 1'b1, 32'h1234, 32'h0,
              1'b0, 1'b0, 2'd2, 1'b0, 0, 0, 0, 32'h0);
        chk("v1_data", rsd_data_o, 32'h00001234);
        chk("v1_wen", 32'(rf_wen_o), 32'h1);

        pin_en    = 1'b1;
        pin_addr  = 32'h100;
        pin_be    = 4'b1000;
        pin_wdata = 32'hABABABAB;
        req0      = req_cycles;
        do_op(32'h104, 32'h23, 5'd0, 1'b1, 32'h103, 32'hAB,
              1'b0, 1'b1, 2'd0, 1'b0, 2, 0, 2, 32'h0);
        pin_en = 1'b0;
        chk("v2_req_cycles", 32'(req_cycles - req0), 32'd3);
        chk("v2_wen", 32'(rf_wen_o), 32'h0);

        do_op(32'h108, 32'h03, 5'd7, 1'b1, 32'h102, 32'h0,
              1'b1, 1'b0, 2'd0, 1'b0, 1, 1, 0, 32'h00800000);
        chk("v3_lb", rsd_data_o, 32'hFFFFFF80);
        do_op(32'h10C, 32'h03, 5'd7, 1'b1, 32'h102, 32'h0,
              1'b1, 1'b0, 2'd0, 1'b1, 0, 2, 0, 32'h00800000);
        chk("v3_lbu", rsd_data_o, 32'h00000080);

        req0 = req_cycles;
        do_op(32'h110, 32'h03, 5'd9, 1'b1, 32'h202, 32'h0,
              1'b1, 1'b0, 2'd2, 1'b0, 0, 0, 0, 32'h0);
        chk("v4_mis", 32'(misalign_o), 32'h1);
        chk("v4_wen", 32'(rf_wen_o), 32'h0);
        chk("v4_noreq", 32'(req_cycles - req0), 32'd0);

        do_op(32'h114, 32'h03, 5'd3, 1'b1, 32'h0, 32'h0,
              1'b1, 1'b0, 2'd1, 1'b0, 0, 0, 1, 32'h0000F00D);
        chk("v5_lh", rsd_data_o, 32'hFFFFF00D);

        for (int n = 0; n < 250; n++) begin
            r    = int'($urandom % 10);
            a    = $urandom;
            if ($urandom % 2 == 1) a = a - (a % 4);
            sz   = 2'($urandom % 3);
            isld = 1'($urandom % 2);
            do_op($urandom, $urandom, 5'($urandom), 1'($urandom % 2), a,
                  $urandom, (r >= 4) && isld, (r >= 4) && !isld, sz,
                  1'($urandom % 2), int'($urandom % 4),
                  int'($urandom % 4), 2, $urandom);
        end

        ex_valid_i   = 1'b1;
        ld_i         = 1'b1;
        st_i         = 1'b0;
        size_i       = 2'd2;
        alu_res_i    = 32'h40;
        exp_wb       = 1'b0;
        exp_ready    = 1'b0;
        exp_req      = 1'b1;
        exp_we       = 1'b0;
        exp_addr     = 32'h40;
        exp_be       = 4'hF;
        exp_wdata    = store_data_i;
        @(negedge clk);
        ex_valid_i    = 1'b0;
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b0;
        exp_req       = 1'b0;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        rst_n      = 1'b0;
        cmp_en     = 1'b0;
        #1;
        chk("v6_req", 32'(dmem_req_o), 32'h0);
        chk("v6_ready", 32'(ex_ready_o), 32'h1);
        chk("v6_wb", 32'(wb_valid_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_exp();
        cmp_en        = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hDEADBEEF;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("v6_after", 32'(wb_valid_o), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
